// File: rtl/edge_tx_buffer_if.sv
// edge_tx_buffer_if: pixel input, UART TX handshake and status lines of the edge TX buffer
interface edge_tx_buffer_if #(
    parameter int CNT_W = 15
);
    logic [7:0]       pix_in;
    logic             pix_flag;
    logic             tx_busy;
    logic [7:0]       tx_data;
    logic             tx_flag;
    logic             fifo_full;
    logic             overflow;
    logic             frame_done;
    logic [CNT_W-1:0] tx_cnt;
    modport master (
        output pix_in, pix_flag, tx_busy,
        input  tx_data, tx_flag, fifo_full, overflow, frame_done, tx_cnt
    );
    modport slave (
        input  pix_in, pix_flag, tx_busy,
        output tx_data, tx_flag, fifo_full, overflow, frame_done, tx_cnt
    );
endinterface

// File: rtl/edge_tx_buffer.sv
// edge_tx_buffer: FIFO between the Sobel edge detector and the UART TX, with frame byte counting
module edge_tx_buffer #(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int OUT_PIXELS = 31684,
    parameter int CNT_W      = 15
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    edge_tx_buffer_if.slave bus
);
    localparam logic [1:0]        IDLE     = 2'd0;
    localparam logic [1:0]        HOLD     = 2'd1;
    localparam logic [1:0]        WAIT     = 2'd2;
    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(OUT_PIXELS - 1);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count, count_nxt;
    logic [1:0]        state;
    logic [7:0]        tx_data;
    logic              tx_flag, fifo_full, overflow, frame_done;
    logic [CNT_W-1:0]  tx_cnt;
    logic              rd, wr;

    // a read is a load into the UART; a full FIFO still accepts when that load frees a slot
    always_comb begin
        rd        = state == IDLE && count != '0 && !bus.tx_busy;
        wr        = bus.pix_flag && (count != FULL_CNT || rd);
        count_nxt = count + (ADDR_W + 1)'(wr) - (ADDR_W + 1)'(rd);
    end

    // storage is not reset; the pointers alone decide which entries are valid
    always_ff @(posedge sys_clk)
        if (wr) mem[wr_ptr] <= bus.pix_in;

    // pointers, occupancy, registered full flag and the sticky drop flag
    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            fifo_full <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (rd) rd_ptr <= rd_ptr + 1'b1;
            count     <= count_nxt;
            fifo_full <= count_nxt == FULL_CNT;
            if (bus.pix_flag && !wr) overflow <= 1'b1;
        end

    // start/busy handshake toward the UART and per-frame byte counting on each load
    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
            state      <= IDLE;
            tx_data    <= 8'h00;
            tx_flag    <= 1'b0;
            frame_done <= 1'b0;
            tx_cnt     <= '0;
        end else begin
            tx_flag    <= rd;
            frame_done <= rd && tx_cnt == LAST_CNT;
            if (rd) begin
                tx_data <= mem[rd_ptr];
                tx_cnt  <= tx_cnt == LAST_CNT ? '0 : tx_cnt + 1'b1;
            end
            state <= rd ? HOLD :
                     state == HOLD ? WAIT :
                     state == WAIT && !bus.tx_busy ? IDLE : state;
        end

    assign bus.tx_data    = tx_data;
    assign bus.tx_flag    = tx_flag;
    assign bus.fifo_full  = fifo_full;
    assign bus.overflow   = overflow;
    assign bus.frame_done = frame_done;
    assign bus.tx_cnt     = tx_cnt;
endmodule
